// File: rtl/issue_scoreboard_ctrl.sv
// issue_scoreboard_ctrl: single-entry issue stage between the decoder and the
// execute/memory back end. A 32-entry scoreboard tracks issued-but-not-retired
// register writes. An instruction is released only when it has no RAW or WAW
// hazard, is under the in-flight limit, and (if serializing) all earlier
// writes have retired. A writeback in the same cycle releases its hazard.
//
// Optional build macro ISSUE_STALL_CNT_EN: when defined, stall_cycles counts
// cycles in which an instruction is held but blocked (saturating). When
// undefined, stall_cycles is tied to 0 and no counter is built.
//
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high. out_valid, once high, holds with stable fields until that transfer,
// except that flush withdraws it. in_ready may depend combinationally on
// out_ready and flush.
module issue_scoreboard_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_rs_valid,
  input  logic             in_rt_valid,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic             in_dst_valid,
  input  logic [4:0]       in_dst,
  input  logic             in_serial,
  input  logic [31:0]      in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_dst_valid,
  output logic [4:0]       out_dst,
  output logic [31:0]      out_tag,
  input  logic             wb_valid,
  input  logic [4:0]       wb_reg,
  input  logic             flush,
  output logic [CNT_W-1:0] inflight,
  output logic             err_wb,
  output logic [31:0]      stall_cycles,
  output logic             dbg_state,
  output logic [31:0]      dbg_scoreboard
);

  typedef enum logic {S_EMPTY = 1'b0, S_HELD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  state_t      state;
  logic [31:0] scoreboard;

  // Held instruction source/control fields (destination and tag are the
  // registered out_* ports).
  logic        h_rs_valid;
  logic        h_rt_valid;
  logic [4:0]  h_rs;
  logic [4:0]  h_rt;
  logic        h_serial;

  logic [31:0] wb_onehot;
  logic [31:0] pend_eff;
  logic        wb_nonzero;
  logic        wb_hit;
  logic        wb_miss;
  logic [CNT_W-1:0] inflight_eff;
  logic        raw;
  logic        waw;
  logic        full;
  logic        drain;
  logic        fire;
  logic        accept;
  logic        set_dst;
  logic [31:0] sb_set;
  logic [31:0] sb_clr;
  logic [CNT_W-1:0] inflight_next;

  // Hazard evaluation against the scoreboard with same-cycle writeback bypass.
  always_comb begin
    wb_onehot    = 32'd1 << wb_reg;
    wb_nonzero   = wb_valid & (wb_reg != 5'd0);
    pend_eff     = scoreboard & ~(wb_valid ? wb_onehot : 32'd0);
    wb_hit       = wb_nonzero & scoreboard[wb_reg];
    wb_miss      = wb_nonzero & ~scoreboard[wb_reg];
    inflight_eff = inflight - {{(CNT_W-1){1'b0}}, wb_hit};
    raw          = (h_rs_valid & pend_eff[h_rs]) | (h_rt_valid & pend_eff[h_rt]);
    waw          = out_dst_valid & pend_eff[out_dst];
    full         = out_dst_valid & (out_dst != 5'd0) & (inflight_eff == MAX_CNT);
    drain        = h_serial & (pend_eff != 32'd0);
    out_valid    = (state == S_HELD) & ~raw & ~waw & ~full & ~drain & ~flush;
    fire         = out_valid & out_ready;
    in_ready     = (state == S_EMPTY) | fire | flush;
    accept       = in_valid & in_ready;
    set_dst      = fire & out_dst_valid & (out_dst != 5'd0);
    sb_set       = set_dst ? (32'd1 << out_dst) : 32'd0;
    sb_clr       = wb_hit ? wb_onehot : 32'd0;
    inflight_next = inflight;
    if (set_dst & ~wb_hit)
      inflight_next = inflight + {{(CNT_W-1){1'b0}}, 1'b1};
    else if (~set_dst & wb_hit)
      inflight_next = inflight - {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Holding-register FSM: capture on accept, drop on fire or flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_EMPTY;
      h_rs_valid    <= 1'b0;
      h_rt_valid    <= 1'b0;
      h_rs          <= 5'd0;
      h_rt          <= 5'd0;
      h_serial      <= 1'b0;
      out_dst_valid <= 1'b0;
      out_dst       <= 5'd0;
      out_tag       <= 32'd0;
    end else begin
      if (accept) begin
        state         <= S_HELD;
        h_rs_valid    <= in_rs_valid;
        h_rt_valid    <= in_rt_valid;
        h_rs          <= in_rs;
        h_rt          <= in_rt;
        h_serial      <= in_serial;
        out_dst_valid <= in_dst_valid;
        out_dst       <= in_dst;
        out_tag       <= in_tag;
      end else if (fire | flush) begin
        state <= S_EMPTY;
      end
    end
  end

  // Scoreboard and in-flight count; an issuing set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scoreboard <= 32'd0;
      inflight   <= '0;
      err_wb     <= 1'b0;
    end else begin
      scoreboard <= (scoreboard & ~sb_clr) | sb_set;
      inflight   <= inflight_next;
      if (wb_miss)
        err_wb <= 1'b1;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of cycles a held instruction is blocked.
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_q <= 32'd0;
    else if ((state == S_HELD) & ~out_valid & ~flush & (stall_q != 32'hFFFF_FFFF))
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

  assign dbg_state      = state;
  assign dbg_scoreboard = scoreboard;

endmodule

// File: doc/issue_scoreboard_ctrl.md
Name: issue_scoreboard_ctrl

Overview:
- Issue controller between the instruction decoder and the execute/memory back end.
- Holds one decoded instruction and tracks pending register writes in a 32-entry scoreboard.
- Releases an instruction only when it has no RAW or WAW hazard and the in-flight limit allows it.
- Serializing instructions (syscall, jr) wait until every earlier write has retired.

Parameters:
- MAX_INFLIGHT, 4, maximum issued-but-not-written-back register writes (1..15).
- CNT_W, 4, width of the in-flight counter; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  decoded instruction offered
- in_ready  out  1  controller can accept
- in_rs_valid / in_rt_valid  in  1 each  source field used
- in_rs / in_rt  in  5 each  source registers
- in_dst_valid  in  1  instruction writes a register
- in_dst  in  5  destination register
- in_serial  in  1  serializing instruction (syscall/jr)
- in_tag  in  32  opaque payload (PC); passed through unchanged
- out_valid  out  1  instruction issued to back end
- out_ready  in  1  back end accepts
- out_dst_valid / out_dst / out_tag  out  1/5/32  held instruction fields
- wb_valid  in  1  register write retiring
- wb_reg  in  5  retiring register
- flush  in  1  drop held instruction
- inflight  out  CNT_W  current in-flight count
- err_wb  out  1  sticky: writeback to a non-pending register
- stall_cycles  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset values (rst_n low at a clk edge):
  - state S_EMPTY; scoreboard all 0; inflight 0; err_wb 0; stall_cycles 0.
  - out_valid 0; out_dst_valid 0; out_dst 0; out_tag 0.
  - Reset overrides every other input in that cycle.
- FSM states: S_EMPTY, S_HELD.
  - in_ready = (state==S_EMPTY) | fire, where fire = out_valid & out_ready.
  - Accept when in_valid & in_ready: capture all fields; state -> S_HELD next cycle.
  - Latency: an accepted instruction can show out_valid on the next cycle.
  - fire without a new accept -> S_EMPTY.
  - fire together with an accept -> stays S_HELD with the new instruction (1 instr/cycle throughput).
- Effective pending mask: pend_eff = scoreboard & ~(wb_valid ? onehot(wb_reg) : 0). A same-cycle writeback releases its hazard.
- Hazards, evaluated on the held instruction:
  - raw = (rs_valid & pend_eff[rs]) | (rt_valid & pend_eff[rt]).
  - waw = dst_valid & pend_eff[dst].
  - full = dst_valid & dst!=0 & (inflight_eff == MAX_INFLIGHT), where inflight_eff = inflight minus a same-cycle valid writeback.
  - drain = serial & (pend_eff != 0).
- out_valid = (state==S_HELD) & ~raw & ~waw & ~full & ~drain & ~flush.
  - out_valid is combinational from registered state plus wb/flush.
  - Once asserted, it stays asserted with fields stable until fire, unless flush.
- Register $0: never set in the scoreboard, never counted, never a hazard.
- On fire with dst_valid and dst!=0: scoreboard[dst] set; inflight +1.
- Writeback (wb_valid, wb_reg != 0):
  - If wb_reg is pending: clear its bit; inflight -1.
  - If not pending: no change; err_wb set until reset.
  - If a fire sets the same register in the same cycle, the set wins and inflight is unchanged (+1 -1).
  - wb_reg == 0 is ignored.
- flush: state -> S_EMPTY; the held instruction is dropped and in_ready stays 1 for that cycle.
  - A simultaneous in_valid is accepted and is not flushed.
  - Scoreboard and inflight are unaffected; already-issued writes still retire.

Optional Feature:
- Macro ISSUE_STALL_CNT_EN.
- Defined: stall_cycles counts cycles with state==S_HELD & ~out_valid & ~flush. It saturates at 0xFFFFFFFF and resets to 0.
- Undefined: stall_cycles is constant 0 and no counter logic is built.

Test Plan:
- Back-to-back independent: addu r3 then addu r4, out_ready=1 -> out_valid on consecutive cycles; inflight 0->1->2; scoreboard bits 3,4 set.
- RAW stall: issue dst r5, next instruction reads rs=r5; wb r5 at cycle N -> second instruction's out_valid rises in cycle N via the bypass; stall_cycles equals stall length when ISSUE_STALL_CNT_EN is defined.
- In-flight limit, MAX_INFLIGHT=2: three writers r1, r2, r3 with no wb -> third held with out_valid=0; wb r1 -> third fires the same cycle; inflight stays 2.
- Serial drain: r7 pending, then syscall -> out_valid=0 until wb r7; syscall issues in the wb cycle; inflight 0.
- Same-cycle set/clear: r9 pending, wb r9 while a new writer to r9 fires -> scoreboard[9]=1, inflight unchanged; wb r10 (not pending) -> err_wb=1 and stays 1.
- Flush and reset: held stalled instruction plus flush -> S_EMPTY, scoreboard kept; rst_n=0 mid-stall -> all outputs and the scoreboard at reset values next cycle.
